// File: rtl/div_controller.sv
// Sequencer between the DIV/DIVU issue logic and the 32-bit unsigned divider:
// operand magnitude conversion, launch/wait handshake, sign fix-up into LO, status flags.
module div_controller #(
  parameter int WATCHDOG = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  input  logic        mflo_req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] lo_out,
  output logic        done,
  output logic        div_by_zero,
  output logic        proto_err,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_do,
  input  logic        div_ready,
  input  logic        div_exc,
  input  logic [31:0] div_q
);

  // state    | meaning
  // S_IDLE   | waiting for start; divider handshake inputs ignored
  // S_LAUNCH | div_do high for this single cycle
  // S_WAIT   | waiting for div_ready, watchdog counting
  // S_FIX    | sign-correct quotient and write LO (or flag divide-by-zero)
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FIX    = 2'd3
  } state_t;

  localparam logic [5:0] WD_CNT = 6'(WATCHDOG);

  state_t      state_q;
  logic        neg_q;
  logic [5:0]  wcnt_q;
  logic [31:0] q_raw_q;
  logic        exc_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        dbz_q;
  logic        perr_q;
  logic [31:0] div_a_q;
  logic [31:0] div_b_q;

  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  // Negation wraps, so -2^31 maps onto its own correct unsigned magnitude.
  assign rs_mag = (is_signed & rs[31]) ? (32'd0 - rs) : rs;
  assign rt_mag = (is_signed & rt[31]) ? (32'd0 - rt) : rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      wcnt_q  <= 6'd0;
      q_raw_q <= 32'd0;
      exc_q   <= 1'b0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      perr_q  <= 1'b0;
      div_a_q <= 32'd0;
      div_b_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            neg_q   <= is_signed & (rs[31] ^ rt[31]);
            div_a_q <= rs_mag;
            div_b_q <= rt_mag;
            dbz_q   <= 1'b0;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wcnt_q  <= 6'd0;
          state_q <= flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q + 6'd1;
          if (flush) begin
            state_q <= S_IDLE;
          end else if (div_ready) begin
            q_raw_q <= div_q;
            exc_q   <= div_exc;
            state_q <= S_FIX;
          end else if (wcnt_q == WD_CNT) begin
            perr_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!flush) begin
            done_q <= 1'b1;
            if (exc_q) begin
              dbz_q <= 1'b1;
            end else begin
              lo_q <= neg_q ? (32'd0 - q_raw_q) : q_raw_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stall       = mflo_req & (busy | start);
  assign div_do      = (state_q == S_LAUNCH);
  assign lo_out      = lo_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign proto_err   = perr_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;

endmodule

// File: tb/tb_div_controller.sv
// Directed testbench for div_controller with a behavioural 32-cycle divider model.
module tb_div_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        flush = 1'b0;
  logic        mflo_req = 1'b0;
  logic        busy, stall, done, div_by_zero, proto_err, div_do;
  logic [31:0] lo_out, div_a, div_b;
  logic        div_ready = 1'b0;
  logic        div_exc = 1'b0;
  logic [31:0] div_q = 32'd0;

  int errors = 0;
  int checks = 0;

  logic        withhold = 1'b0;
  logic        m_active = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_do_s, m_rst_s;
  logic [31:0] m_a_s, m_b_s;

  div_controller #(.WATCHDOG(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .rs(rs), .rt(rt), .flush(flush), .mflo_req(mflo_req),
    .busy(busy), .stall(stall), .lo_out(lo_out), .done(done),
    .div_by_zero(div_by_zero), .proto_err(proto_err),
    .div_a(div_a), .div_b(div_b), .div_do(div_do),
    .div_ready(div_ready), .div_exc(div_exc), .div_q(div_q)
  );

  always #5 clk = ~clk;

  // Divider model: ready 32 cycles after div_do; a new div_do restarts it.
  always @(posedge clk) begin
    m_do_s  = div_do;
    m_a_s   = div_a;
    m_b_s   = div_b;
    m_rst_s = rst_n;
    #1;
    div_ready = 1'b0;
    div_exc   = 1'b0;
    if (!m_rst_s) begin
      m_active = 1'b0;
    end else if (m_do_s) begin
      m_active = 1'b1;
      m_rem    = 31;
      m_a      = m_a_s;
      m_b      = m_b_s;
    end else if (m_active && m_rem > 0) begin
      m_rem = m_rem - 1;
    end
    if (m_active && m_rem == 0) begin
      m_active = 1'b0;
      if (!withhold) begin
        div_ready = 1'b1;
        div_exc   = (m_b == 32'd0);
        div_q     = (m_b == 32'd0) ? 32'hFFFF_FFFF : m_a / m_b;
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_out); end
    checks++; if ({done, div_by_zero, proto_err, div_do} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {done, div_by_zero, proto_err, div_do}); end
    checks++; if ({div_a, div_b} !== 64'd0) begin errors++; $display("FAIL reset_div_ab got %h/%h want 0/0", div_a, div_b); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    for (int cyc = 0; cyc <= 36; cyc++) begin
      @(negedge clk);
      start = (cyc == 0); is_signed = 1'b0; rs = 32'd100; rt = 32'd7;
      #1;
      checks++; if (div_do !== (cyc == 1)) begin errors++; $display("FAIL divu_div_do cyc=%0d got %0b want %0b", cyc, div_do, cyc == 1); end
      checks++; if (busy !== (cyc >= 1 && cyc <= 34)) begin errors++; $display("FAIL divu_busy cyc=%0d got %0b want %0b", cyc, busy, (cyc >= 1 && cyc <= 34)); end
      checks++; if (done !== (cyc == 35)) begin errors++; $display("FAIL divu_done cyc=%0d got %0b want %0b", cyc, done, cyc == 35); end
      if (cyc == 1) begin
        checks++; if (div_a !== 32'd100 || div_b !== 32'd7) begin errors++; $display("FAIL divu_ab got %0d/%0d want 100/7", div_a, div_b); end
      end
      if (cyc == 35) begin
        checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo_out); end
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] rt_v [2];
    logic [31:0] lo_v [2];
    rt_v[0] = 32'd7;          lo_v[0] = 32'hFFFF_FFF2;
    rt_v[1] = 32'hFFFF_FFF9;  lo_v[1] = 32'd14;
    for (int v = 0; v < 2; v++) begin
      for (int cyc = 0; cyc <= 35; cyc++) begin
        @(negedge clk);
        start = (cyc == 0); is_signed = 1'b1; rs = 32'hFFFF_FF9C; rt = rt_v[v];
        #1;
        if (cyc == 1) begin
          checks++; if (div_a !== 32'd100 || div_b !== 32'd7) begin errors++; $display("FAIL signed_ab v=%0d got %h/%h want 100/7", v, div_a, div_b); end
        end
        if (cyc == 35) begin
          checks++; if (done !== 1'b1) begin errors++; $display("FAIL signed_done v=%0d got %0b want 1", v, done); end
          checks++; if (lo_out !== lo_v[v]) begin errors++; $display("FAIL signed_lo v=%0d got %h want %h", v, lo_out, lo_v[v]); end
        end
      end
    end
    start = 1'b0; is_signed = 1'b0;
  endtask

  task automatic test_div_by_zero();
    logic [31:0] rs_v [3];
    logic [31:0] rt_v [3];
    logic [31:0] lo_v [3];
    rs_v[0] = 32'h1234; rt_v[0] = 32'd1; lo_v[0] = 32'h1234;
    rs_v[1] = 32'd5;    rt_v[1] = 32'd0; lo_v[1] = 32'h1234;
    rs_v[2] = 32'd8;    rt_v[2] = 32'd2; lo_v[2] = 32'd4;
    for (int op = 0; op < 3; op++) begin
      for (int cyc = 0; cyc <= 35; cyc++) begin
        @(negedge clk);
        start = (cyc == 0); is_signed = 1'b0; rs = rs_v[op]; rt = rt_v[op];
        #1;
        if (cyc == 1) begin
          checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear op=%0d got %0b want 0", op, div_by_zero); end
        end
        if (cyc == 35) begin
          checks++; if (done !== 1'b1) begin errors++; $display("FAIL dbz_done op=%0d got %0b want 1", op, done); end
          checks++; if (div_by_zero !== (op == 1)) begin errors++; $display("FAIL dbz_flag op=%0d got %0b want %0b", op, div_by_zero, op == 1); end
          checks++; if (lo_out !== lo_v[op]) begin errors++; $display("FAIL dbz_lo op=%0d got %h want %h", op, lo_out, lo_v[op]); end
        end
      end
    end
  endtask

  task automatic test_flush();
    // lo_out is 4 here; flush in WAIT, then a fresh op
    for (int cyc = 0; cyc <= 48; cyc++) begin
      @(negedge clk);
      start = (cyc == 0 || cyc == 12); flush = (cyc == 10);
      rs = (cyc < 12) ? 32'd100 : 32'd9; rt = (cyc < 12) ? 32'd7 : 32'd3;
      #1;
      checks++; if (done !== (cyc == 47)) begin errors++; $display("FAIL flush_done cyc=%0d got %0b want %0b", cyc, done, cyc == 47); end
      if (cyc == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %0b want 0", busy); end
      end
      if (cyc == 13) begin
        checks++; if (div_do !== 1'b1) begin errors++; $display("FAIL flush_relaunch got %0b want 1", div_do); end
      end
      if (cyc == 35) begin
        checks++; if (lo_out !== 32'd4) begin errors++; $display("FAIL flush_lo_kept got %h want 4", lo_out); end
      end
      if (cyc == 47) begin
        checks++; if (lo_out !== 32'd3) begin errors++; $display("FAIL flush_lo got %h want 3", lo_out); end
      end
    end
    // Flush while in FIX beats the LO write
    for (int cyc = 0; cyc <= 37; cyc++) begin
      @(negedge clk);
      start = (cyc == 0); flush = (cyc == 34); rs = 32'd50; rt = 32'd5;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL flushfix_done cyc=%0d got %0b want 0", cyc, done); end
      if (cyc == 36) begin
        checks++; if (lo_out !== 32'd3) begin errors++; $display("FAIL flushfix_lo got %h want 3", lo_out); end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_watchdog();
    withhold = 1'b1;
    for (int cyc = 0; cyc <= 45; cyc++) begin
      @(negedge clk);
      start = (cyc == 0); rs = 32'd10; rt = 32'd2;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL wd_done cyc=%0d got %0b want 0", cyc, done); end
      checks++; if (busy !== (cyc >= 1 && cyc <= 42)) begin errors++; $display("FAIL wd_busy cyc=%0d got %0b want %0b", cyc, busy, (cyc >= 1 && cyc <= 42)); end
      checks++; if (proto_err !== (cyc >= 43)) begin errors++; $display("FAIL wd_perr cyc=%0d got %0b want %0b", cyc, proto_err, cyc >= 43); end
    end
    checks++; if (lo_out !== 32'd3) begin errors++; $display("FAIL wd_lo got %h want 3", lo_out); end
    withhold = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == 0); rs = 32'd100; rt = 32'd7;
      if (cyc == 20) rst_n = 1'b0;
      if (cyc == 21) rst_n = 1'b1;
      #1;
      if (cyc == 19) begin
        checks++; if (proto_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got perr=%0b busy=%0b want 1 1", proto_err, busy); end
      end
      if (cyc == 20) begin
        checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h want 0", lo_out); end
        checks++; if ({busy, done, div_by_zero, proto_err, div_do} !== 5'b0) begin errors++; $display("FAIL rmid_flags got %b want 00000", {busy, done, div_by_zero, proto_err, div_do}); end
        checks++; if ({div_a, div_b} !== 64'd0) begin errors++; $display("FAIL rmid_ab got %h/%h want 0/0", div_a, div_b); end
      end
      if (cyc > 20) begin
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after cyc=%0d got done=%0b busy=%0b want 0 0", cyc, done, busy); end
      end
    end
  endtask

  task automatic test_minint_stall();
    for (int cyc = 0; cyc <= 36; cyc++) begin
      @(negedge clk);
      start = (cyc == 0); is_signed = 1'b1; rs = 32'h8000_0000; rt = 32'hFFFF_FFFF;
      mflo_req = (cyc <= 35);
      #1;
      if (cyc <= 35) begin
        checks++; if (stall !== (cyc <= 34)) begin errors++; $display("FAIL stall cyc=%0d got %0b want %0b", cyc, stall, cyc <= 34); end
      end
      if (cyc == 1) begin
        checks++; if (div_a !== 32'h8000_0000 || div_b !== 32'd1) begin errors++; $display("FAIL minint_ab got %h/%h want 80000000/00000001", div_a, div_b); end
      end
      if (cyc == 35) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL minint_done got %0b want 1", done); end
        checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL minint_lo got %h want 80000000", lo_out); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL minint_dbz got %0b want 0", div_by_zero); end
      end
    end
    mflo_req = 1'b0; is_signed = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Start at 10 is ignored (busy); start at 35 coincides with done and a flush
    for (int cyc = 0; cyc <= 71; cyc++) begin
      @(negedge clk);
      start = (cyc == 0 || cyc == 10 || cyc == 35); flush = (cyc == 35); is_signed = 1'b0;
      rs = (cyc == 0) ? 32'd20 : (cyc == 10) ? 32'd99 : 32'd21;
      rt = (cyc == 0) ? 32'd4 : (cyc == 10) ? 32'd1 : 32'd3;
      #1;
      checks++; if (div_do !== (cyc == 1 || cyc == 36)) begin errors++; $display("FAIL b2b_div_do cyc=%0d got %0b want %0b", cyc, div_do, (cyc == 1 || cyc == 36)); end
      checks++; if (done !== (cyc == 35 || cyc == 70)) begin errors++; $display("FAIL b2b_done cyc=%0d got %0b want %0b", cyc, done, (cyc == 35 || cyc == 70)); end
      if (cyc == 35) begin
        checks++; if (lo_out !== 32'd5) begin errors++; $display("FAIL b2b_lo1 got %h want 5", lo_out); end
      end
      if (cyc == 70) begin
        checks++; if (lo_out !== 32'd7) begin errors++; $display("FAIL b2b_lo2 got %h want 7", lo_out); end
      end
    end
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_flush();
    test_watchdog();
    test_reset_mid();
    test_minint_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_controller.md
# div_controller

Sequencer between the MIPS pipeline's DIV/DIVU issue logic and the 32-bit unsigned non-restoring divider. It latches operands and converts signed operands to magnitudes. It launches the divider with a single-cycle start pulse, waits for the divider's ready pulse, then applies sign correction and writes the quotient into the LO register. It also generates the busy, stall, done and divide-by-zero status seen by the pipeline, and supports pipeline flush and a protocol watchdog.

## Interface
Parameters:
- WATCHDOG, 40, cycles in WAIT before a missing ready pulse is declared a protocol error (must be > 32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue DIV/DIVU; sampled only in IDLE
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
- rs  in  32  dividend; sampled with start
- rt  in  32  divisor; sampled with start
- flush  in  1  abort the in-flight operation
- mflo_req  in  1  pipeline wants to read LO
- busy  out  1  state != IDLE
- stall  out  1  mflo_req & (busy | start)
- lo_out  out  32  LO register
- done  out  1  one-cycle pulse; lo_out already holds the new value
- div_by_zero  out  1  sticky; cleared by the next accepted start
- proto_err  out  1  sticky watchdog flag; cleared by reset only
- div_a  out  32  dividend magnitude to the divider (registered)
- div_b  out  32  divisor magnitude to the divider (registered)
- div_do  out  1  divider start pulse
- div_ready  in  1  divider result-valid pulse
- div_exc  in  1  divider divide-by-zero flag, valid with div_ready
- div_q  in  32  divider quotient, valid with div_ready

## Operation
States: IDLE, LAUNCH, WAIT, FIX.

IDLE:
- div_do = 0; div_ready, div_exc and div_q are ignored, so stale pulses from aborted operations are discarded.
- On start: latch neg_q = is_signed & (rs[31] ^ rt[31]).
- div_a = (is_signed & rs[31]) ? -rs : rs; div_b = (is_signed & rt[31]) ? -rt : rt.
- Clear div_by_zero and go to LAUNCH.

LAUNCH:
- div_do = 1 for exactly this cycle.
- Clear the 6-bit wait counter and go to WAIT.

WAIT:
- The counter increments every cycle.
- On div_ready: capture div_q into q_raw and div_exc into exc_r, then go to FIX.
- If the counter reaches WATCHDOG first: set proto_err and go to IDLE without done.

FIX:
- If exc_r: set div_by_zero and leave LO unchanged.
- Otherwise: LO <= neg_q ? -q_raw : q_raw.
- Go to IDLE; done is registered, so it pulses in the first IDLE cycle after FIX.

Arithmetic rules:
- All negations are 32-bit two's complement, wrapping.
- -2^31 / -1: the magnitude is 0x80000000 and neg_q = 0, so LO = 0x80000000.
- -2^31 as dividend has magnitude 0x80000000, which is the correct unsigned value.

Flush:
- flush in LAUNCH, WAIT or FIX goes to IDLE next cycle.
- No LO write, no done; div_by_zero is unchanged.
- flush has priority over div_ready and over the FIX write.
- A later start re-asserts div_do, which restarts the divider counter even if it is still running.

Other rules:
- start while busy is ignored; the issuing stage must use stall/busy.
- flush together with start in IDLE: start is accepted.
- Asynchronous reset: IDLE, lo_out = 0, all flags 0, div_do = 0, div_a = div_b = 0, done = 0. Reset mid-operation abandons it with no LO write.

## Timing
Cycle-by-cycle, with start sampled in cycle 0:
- Cycle 1 (LAUNCH): div_do = 1.
- Cycle 33: the divider asserts div_ready, 32 cycles after div_do.
- Cycle 34: FIX.
- Cycle 35: lo_out updated and done = 1.

Flow rules:
- busy is high in cycles 1–34. Total latency from start to done is 35 cycles.
- Back-to-back: a new start is accepted in cycle 35, while done is high.
- stall is combinational: mflo_req in cycle 0 with start stalls; mflo_req in cycle 35 reads the new LO.
- The WAIT counter measures from the first WAIT cycle; a normal divider gives ready at count 31.

## Test plan
- DIVU rs=100, rt=7 at cycle 0 -> div_do only in cycle 1; div_a=100, div_b=7; done and lo_out=14 in cycle 35; busy high cycles 1–34.
- DIV rs=0xFFFFFF9C (-100), rt=7 -> div_a=100; lo_out=0xFFFFFFF2 (-14) at cycle 35. Repeat with rs=-100, rt=-7 -> lo_out=14.
- DIVU rs=5, rt=0 with LO preloaded to 0x1234 -> div_by_zero=1 and done at cycle 35, lo_out stays 0x1234. The next start clears div_by_zero.
- Flush interrupting an in-flight operation:
  - DIVU 100/7, flush at cycle 10, new DIVU 9/3 at cycle 12.
  - Required: the stale ready pulse from the first operation is ignored; lo_out=3 with done at cycle 47; no done near cycle 35.
- Divider model withholding div_ready -> proto_err set at WAIT count 40, state returns to IDLE, no done. Separately, rst_n low at cycle 20 -> all outputs at reset values immediately, lo_out=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, div_by_zero=0. Also mflo_req held cycles 0–35 -> stall high cycles 0–34, low at 35.
